// File: rtl/yapay_zeka_denetleyici.sv
// ---------------------------------------------------------------------------
// yapay_zeka_denetleyici - issue/sequencing stage in front of the AI accelerator (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module yapay_zeka_denetleyici #(
  parameter int MATRIS_BOYUT = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            istek_gecerli_i,
  output logic                            istek_hazir_o,
  input  logic [2:0]                      islem_i,
  input  logic                            rs2_gecerli_i,
  input  logic [31:0]                     rs1_deger_i,
  input  logic [31:0]                     rs2_deger_i,
  input  logic [4:0]                      rd_adres_i,
  output logic                            blok_aktif_o,
  output logic [31:0]                     filtre_rs1_o,
  output logic [31:0]                     filtre_rs2_o,
  output logic [31:0]                     veri_rs1_o,
  output logic [31:0]                     veri_rs2_o,
  output logic                            filtre_rs1_en_o,
  output logic                            filtre_rs2_en_o,
  output logic                            veri_rs1_en_o,
  output logic                            veri_rs2_en_o,
  output logic                            filtre_sil_o,
  output logic                            veri_sil_o,
  output logic                            conv_yap_yaz_en_o,
  input  logic [31:0]                     conv_sonuc_i,
  input  logic                            conv_hazir_i,
  output logic                            sonuc_gecerli_o,
  input  logic                            sonuc_hazir_i,
  output logic [31:0]                     sonuc_o,
  output logic [4:0]                      sonuc_rd_o,
  output logic [$clog2(MATRIS_BOYUT):0]   filtre_sayac_o,
  output logic [$clog2(MATRIS_BOYUT):0]   veri_sayac_o,
  output logic                            hata_o
);

  localparam int              c_SW  = $clog2(MATRIS_BOYUT) + 1;
  localparam logic [c_SW-1:0] c_MAX = c_SW'(MATRIS_BOYUT);
  localparam logic [c_SW-1:0] c_BIR = c_SW'(1);

  localparam logic [2:0] c_FILTRE_YUKLE = 3'd0;
  localparam logic [2:0] c_VERI_YUKLE   = 3'd1;
  localparam logic [2:0] c_FILTRE_SIL   = 3'd2;
  localparam logic [2:0] c_VERI_SIL     = 3'd3;
  localparam logic [2:0] c_CONV_YAP     = 3'd4;

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    BOSALT      = 2'd1,
    SONUC_BEKLE = 2'd2,
    YAZ         = 2'd3
  } durum_t;

  durum_t          durum_q, durum_d;
  logic [c_SW-1:0] f_q, f_d, v_q, v_d, t_q, t_d;
  logic [31:0]     sonuc_q, sonuc_d;
  logic [4:0]      rd_q, rd_d;
  logic            hata_q, hata_d;

  logic            w_kabul, w_hazir, w_gecerli;
  logic            w_fe1, w_fe2, w_ve1, w_ve2, w_fsil, w_vsil, w_conv;
  logic [c_SW-1:0] w_artis, w_min, w_bekleyen;
  logic [c_SW:0]   w_f_yeni, w_v_yeni;
  logic            w_f_tasma, w_v_tasma;

  assign w_artis    = rs2_gecerli_i ? c_SW'(2) : c_BIR;
  assign w_min      = (f_q < v_q) ? f_q : v_q;
  assign w_bekleyen = w_min - t_q;
  assign w_f_yeni   = {1'b0, f_q} + {1'b0, w_artis};
  assign w_v_yeni   = {1'b0, v_q} + {1'b0, w_artis};
  assign w_f_tasma  = w_f_yeni > {1'b0, c_MAX};
  assign w_v_tasma  = w_v_yeni > {1'b0, c_MAX};
  assign w_kabul    = istek_gecerli_i && istek_hazir_o;

  always_comb begin
    durum_d   = durum_q;
    f_d       = f_q;
    v_d       = v_q;
    // The accelerator commits one product per cycle while pairs are pending.
    t_d       = (w_bekleyen != '0) ? t_q + c_BIR : t_q;
    sonuc_d   = sonuc_q;
    rd_d      = rd_q;
    hata_d    = 1'b0;
    w_hazir   = 1'b0;
    w_gecerli = 1'b0;
    w_fe1     = 1'b0;
    w_fe2     = 1'b0;
    w_ve1     = 1'b0;
    w_ve2     = 1'b0;
    w_fsil    = 1'b0;
    w_vsil    = 1'b0;
    w_conv    = 1'b0;
    case (durum_q)
      BOSTA: begin
        w_hazir = 1'b1;
        if (w_kabul) begin
          case (islem_i)
            c_FILTRE_YUKLE: begin
              if (w_f_tasma) begin
                hata_d = 1'b1;
              end else begin
                w_fe1 = 1'b1;
                w_fe2 = rs2_gecerli_i;
                f_d   = w_f_yeni[c_SW-1:0];
              end
            end
            c_VERI_YUKLE: begin
              if (w_v_tasma) begin
                hata_d = 1'b1;
              end else begin
                w_ve1 = 1'b1;
                w_ve2 = rs2_gecerli_i;
                v_d   = w_v_yeni[c_SW-1:0];
              end
            end
            c_FILTRE_SIL: begin
              w_fsil = 1'b1;
              f_d    = '0;
              t_d    = '0;
            end
            c_VERI_SIL: begin
              w_vsil = 1'b1;
              v_d    = '0;
              t_d    = '0;
            end
            c_CONV_YAP: begin
              rd_d = rd_adres_i;
              if (w_bekleyen <= c_BIR) begin
                w_conv  = 1'b1;
                durum_d = SONUC_BEKLE;
              end else begin
                durum_d = BOSALT;
              end
            end
            default: hata_d = 1'b1;
          endcase
        end
      end
      BOSALT: begin
        if (w_bekleyen <= c_BIR) begin
          w_conv  = 1'b1;
          durum_d = SONUC_BEKLE;
        end
      end
      SONUC_BEKLE: begin
        if (conv_hazir_i) begin
          sonuc_d = conv_sonuc_i;
          durum_d = YAZ;
        end
      end
      YAZ: begin
        w_gecerli = 1'b1;
        if (sonuc_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q <= BOSTA;
      f_q     <= '0;
      v_q     <= '0;
      t_q     <= '0;
      sonuc_q <= '0;
      rd_q    <= '0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      f_q     <= f_d;
      v_q     <= v_d;
      t_q     <= t_d;
      sonuc_q <= sonuc_d;
      rd_q    <= rd_d;
      hata_q  <= hata_d;
    end
  end

  // Combinational outputs are forced low while reset is held, not just after an edge.
  assign blok_aktif_o      = !rst_i;
  assign istek_hazir_o     = w_hazir   && !rst_i;
  assign sonuc_gecerli_o   = w_gecerli && !rst_i;
  assign filtre_rs1_en_o   = w_fe1     && !rst_i;
  assign filtre_rs2_en_o   = w_fe2     && !rst_i;
  assign veri_rs1_en_o     = w_ve1     && !rst_i;
  assign veri_rs2_en_o     = w_ve2     && !rst_i;
  assign filtre_sil_o      = w_fsil    && !rst_i;
  assign veri_sil_o        = w_vsil    && !rst_i;
  assign conv_yap_yaz_en_o = w_conv    && !rst_i;
  assign filtre_rs1_o      = rst_i ? '0 : rs1_deger_i;
  assign filtre_rs2_o      = rst_i ? '0 : rs2_deger_i;
  assign veri_rs1_o        = rst_i ? '0 : rs1_deger_i;
  assign veri_rs2_o        = rst_i ? '0 : rs2_deger_i;
  assign sonuc_o           = sonuc_q;
  assign sonuc_rd_o        = rd_q;
  assign filtre_sayac_o    = f_q;
  assign veri_sayac_o      = v_q;
  assign hata_o            = hata_q;

endmodule

`default_nettype wire

// File: tb/tb_yapay_zeka_denetleyici.sv
// ---------------------------------------------------------------------------
// tb_yapay_zeka_denetleyici - directed bench with a small accelerator model (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_yapay_zeka_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        istek_gecerli_i, istek_hazir_o;
  logic [2:0]  islem_i;
  logic        rs2_gecerli_i;
  logic [31:0] rs1_deger_i, rs2_deger_i;
  logic [4:0]  rd_adres_i;
  logic        blok_aktif_o;
  logic [31:0] filtre_rs1_o, filtre_rs2_o, veri_rs1_o, veri_rs2_o;
  logic        filtre_rs1_en_o, filtre_rs2_en_o, veri_rs1_en_o, veri_rs2_en_o;
  logic        filtre_sil_o, veri_sil_o, conv_yap_yaz_en_o;
  logic [31:0] conv_sonuc_i;
  logic        conv_hazir_i;
  logic        sonuc_gecerli_o, sonuc_hazir_i;
  logic [31:0] sonuc_o;
  logic [4:0]  sonuc_rd_o;
  logic [4:0]  filtre_sayac_o, veri_sayac_o;
  logic        hata_o;

  int n_vec = 0;
  int n_err = 0;

  yapay_zeka_denetleyici #(.MATRIS_BOYUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
    .islem_i(islem_i), .rs2_gecerli_i(rs2_gecerli_i),
    .rs1_deger_i(rs1_deger_i), .rs2_deger_i(rs2_deger_i), .rd_adres_i(rd_adres_i),
    .blok_aktif_o(blok_aktif_o),
    .filtre_rs1_o(filtre_rs1_o), .filtre_rs2_o(filtre_rs2_o),
    .veri_rs1_o(veri_rs1_o), .veri_rs2_o(veri_rs2_o),
    .filtre_rs1_en_o(filtre_rs1_en_o), .filtre_rs2_en_o(filtre_rs2_en_o),
    .veri_rs1_en_o(veri_rs1_en_o), .veri_rs2_en_o(veri_rs2_en_o),
    .filtre_sil_o(filtre_sil_o), .veri_sil_o(veri_sil_o),
    .conv_yap_yaz_en_o(conv_yap_yaz_en_o),
    .conv_sonuc_i(conv_sonuc_i), .conv_hazir_i(conv_hazir_i),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i),
    .sonuc_o(sonuc_o), .sonuc_rd_o(sonuc_rd_o),
    .filtre_sayac_o(filtre_sayac_o), .veri_sayac_o(veri_sayac_o),
    .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  // Accelerator stand-in: strobes are snapshotted late in the cycle so the
  // model never races the DUT state register at the rising edge.
  int          mf[16];
  int          md[16];
  int          nf, nd, acc, lim;
  logic        s_fe1, s_fe2, s_ve1, s_ve2, s_fsil, s_vsil, s_conv;
  logic [31:0] s_f1, s_f2, s_v1, s_v2;

  always @(negedge clk_i) begin
    #3;
    s_fe1 = filtre_rs1_en_o; s_fe2 = filtre_rs2_en_o;
    s_ve1 = veri_rs1_en_o;   s_ve2 = veri_rs2_en_o;
    s_fsil = filtre_sil_o;   s_vsil = veri_sil_o;
    s_conv = conv_yap_yaz_en_o;
    s_f1 = filtre_rs1_o; s_f2 = filtre_rs2_o;
    s_v1 = veri_rs1_o;   s_v2 = veri_rs2_o;
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nf = 0; nd = 0;
      conv_hazir_i <= 1'b0;
      conv_sonuc_i <= '0;
    end else begin
      conv_hazir_i <= s_conv;
      if (s_conv) begin
        acc = 0;
        lim = (nf < nd) ? nf : nd;
        for (int i = 0; i < lim; i++) acc += mf[i] * md[i];
        conv_sonuc_i <= acc;
      end
      if (s_fe1 && nf < 16) begin mf[nf] = int'(s_f1); nf++; end
      if (s_fe2 && nf < 16) begin mf[nf] = int'(s_f2); nf++; end
      if (s_ve1 && nd < 16) begin md[nd] = int'(s_v1); nd++; end
      if (s_ve2 && nd < 16) begin md[nd] = int'(s_v2); nd++; end
      if (s_fsil) nf = 0;
      if (s_vsil) nd = 0;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_vec++;
    if (gozlenen !== beklenen) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, gozlenen, beklenen);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic v2, input logic [4:0] rd);
    @(negedge clk_i);
    istek_gecerli_i = 1'b1;
    islem_i         = op;
    rs1_deger_i     = a;
    rs2_deger_i     = b;
    rs2_gecerli_i   = v2;
    rd_adres_i      = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    istek_gecerli_i = 1'b0;
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic v2);
    issue(op, a, b, v2, 5'd0);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_gecerli(input string tag, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      #1;
      if (sonuc_gecerli_o) begin
        n = k;
        break;
      end
    end
    if (n == 0) check_value({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int lat;

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    istek_gecerli_i = 1'b0; islem_i = '0; rs2_gecerli_i = 1'b0;
    rs1_deger_i = '0; rs2_deger_i = '0; rd_adres_i = '0;
    sonuc_hazir_i = 1'b1;

    // Reset state
    #2;
    check_value("rst_blok_aktif", 32'(blok_aktif_o), 32'd0);
    check_value("rst_istek_hazir", 32'(istek_hazir_o), 32'd0);
    check_value("rst_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    check_value("rst_sonuc", sonuc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_value("rel_istek_hazir", 32'(istek_hazir_o), 32'd1);
    check_value("rel_blok_aktif", 32'(blok_aktif_o), 32'd1);
    check_value("rel_F", 32'(filtre_sayac_o), 32'd0);
    check_value("rel_V", 32'(veri_sayac_o), 32'd0);

    // Basic convolution: 1*5+2*6+3*7+4*8 = 70
    issue(3'd0, 32'd1, 32'd2, 1'b1, 5'd0);
    check_value("fy_en1", 32'(filtre_rs1_en_o), 32'd1);
    check_value("fy_en2", 32'(filtre_rs2_en_o), 32'd1);
    check_value("fy_ven1", 32'(veri_rs1_en_o), 32'd0);
    tick();
    load(3'd0, 32'd3, 32'd4, 1'b1);
    load(3'd1, 32'd5, 32'd6, 1'b1);
    load(3'd1, 32'd7, 32'd8, 1'b1);
    issue(3'd4, 32'd0, 32'd0, 1'b0, 5'd10);
    check_value("basic_conv_en_c", 32'(conv_yap_yaz_en_o), 32'd0);
    tick();
    wait_gecerli("basic", lat);
    check_value("basic_sonuc", sonuc_o, 32'd70);
    check_value("basic_rd", 32'(sonuc_rd_o), 32'd10);
    check_value("basic_F", 32'(filtre_sayac_o), 32'd4);
    check_value("basic_V", 32'(veri_sayac_o), 32'd4);

    // Drain: B=2 at CONV_YAP gives exactly one BOSALT cycle
    do_reset();
    load(3'd0, 32'd1, 32'd2, 1'b1);
    load(3'd1, 32'd3, 32'd4, 1'b1);
    issue(3'd4, 32'd0, 32'd0, 1'b0, 5'd5);
    check_value("drain_hazir_c", 32'(istek_hazir_o), 32'd1);
    check_value("drain_conv_c", 32'(conv_yap_yaz_en_o), 32'd0);
    tick();
    check_value("drain_hazir_c1", 32'(istek_hazir_o), 32'd0);
    check_value("drain_conv_c1", 32'(conv_yap_yaz_en_o), 32'd1);
    @(posedge clk_i); #1;
    check_value("drain_conv_c2", 32'(conv_yap_yaz_en_o), 32'd0);
    check_value("drain_gecerli_c2", 32'(sonuc_gecerli_o), 32'd0);
    @(posedge clk_i); #1;
    check_value("drain_gecerli_c3", 32'(sonuc_gecerli_o), 32'd1);
    check_value("drain_sonuc", sonuc_o, 32'd11);
    check_value("drain_rd", 32'(sonuc_rd_o), 32'd5);

    // Overflow at 15 filter elements with a double load
    do_reset();
    for (int i = 0; i < 7; i++) load(3'd0, 32'd1, 32'd1, 1'b1);
    load(3'd0, 32'd1, 32'd0, 1'b0);
    check_value("ovf_F15", 32'(filtre_sayac_o), 32'd15);
    issue(3'd0, 32'd9, 32'd9, 1'b1, 5'd0);
    check_value("ovf_en1", 32'(filtre_rs1_en_o), 32'd0);
    check_value("ovf_en2", 32'(filtre_rs2_en_o), 32'd0);
    check_value("ovf_hata_pre", 32'(hata_o), 32'd0);
    tick();
    check_value("ovf_hata", 32'(hata_o), 32'd1);
    check_value("ovf_F_held", 32'(filtre_sayac_o), 32'd15);
    issue(3'd0, 32'd1, 32'd0, 1'b0, 5'd0);
    check_value("ovf_single_en", 32'(filtre_rs1_en_o), 32'd1);
    tick();
    check_value("ovf_hata_once", 32'(hata_o), 32'd0);
    check_value("ovf_F16", 32'(filtre_sayac_o), 32'd16);

    // Clear data, then CONV_YAP sees no pairs
    do_reset();
    load(3'd0, 32'd1, 32'd2, 1'b1);
    load(3'd0, 32'd3, 32'd4, 1'b1);
    load(3'd1, 32'd5, 32'd6, 1'b1);
    load(3'd1, 32'd7, 32'd8, 1'b1);
    issue(3'd3, 32'd0, 32'd0, 1'b0, 5'd0);
    check_value("vsil_strobe", 32'(veri_sil_o), 32'd1);
    check_value("vsil_fsil", 32'(filtre_sil_o), 32'd0);
    tick();
    check_value("vsil_V", 32'(veri_sayac_o), 32'd0);
    check_value("vsil_F", 32'(filtre_sayac_o), 32'd4);
    issue(3'd4, 32'd0, 32'd0, 1'b0, 5'd3);
    check_value("vsil_strobe_off", 32'(veri_sil_o), 32'd0);
    check_value("clr_conv_c", 32'(conv_yap_yaz_en_o), 32'd1);
    tick();
    wait_gecerli("clr", lat);
    check_value("clr_latency", 32'(lat), 32'd2);
    check_value("clr_sonuc", sonuc_o, 32'd0);
    check_value("clr_rd", 32'(sonuc_rd_o), 32'd3);
    issue(3'd6, 32'd1, 32'd1, 1'b1, 5'd0);
    check_value("ill_hata_pre", 32'(hata_o), 32'd0);
    check_value("ill_fen", 32'(filtre_rs1_en_o), 32'd0);
    check_value("ill_ven", 32'(veri_rs1_en_o), 32'd0);
    check_value("ill_conv", 32'(conv_yap_yaz_en_o), 32'd0);
    tick();
    check_value("ill_hata", 32'(hata_o), 32'd1);
    check_value("ill_F", 32'(filtre_sayac_o), 32'd4);
    check_value("ill_V", 32'(veri_sayac_o), 32'd0);
    @(posedge clk_i); #1;
    check_value("ill_hata_once", 32'(hata_o), 32'd0);

    // Backpressure in YAZ: 2*3 = 6
    do_reset();
    sonuc_hazir_i = 1'b0;
    load(3'd0, 32'd2, 32'd0, 1'b0);
    load(3'd1, 32'd3, 32'd0, 1'b0);
    issue(3'd4, 32'd0, 32'd0, 1'b0, 5'd7);
    tick();
    wait_gecerli("bp", lat);
    check_value("bp_sonuc", sonuc_o, 32'd6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); #1;
      check_value("bp_gecerli_hold", 32'(sonuc_gecerli_o), 32'd1);
      check_value("bp_sonuc_hold", sonuc_o, 32'd6);
      check_value("bp_hazir_low", 32'(istek_hazir_o), 32'd0);
    end
    sonuc_hazir_i = 1'b1;
    @(negedge clk_i); #1;
    check_value("bp_hazir_back", 32'(istek_hazir_o), 32'd1);
    check_value("bp_gecerli_drop", 32'(sonuc_gecerli_o), 32'd0);

    // Running sum survives conv_run; then async reset inside YAZ
    sonuc_hazir_i = 1'b0;
    issue(3'd4, 32'd0, 32'd0, 1'b0, 5'd8);
    tick();
    wait_gecerli("bp2", lat);
    check_value("bp2_sonuc", sonuc_o, 32'd6);
    check_value("bp2_rd", 32'(sonuc_rd_o), 32'd8);
    #1;
    rst_i = 1'b1;
    #1;
    check_value("arst_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    check_value("arst_hazir", 32'(istek_hazir_o), 32'd0);
    check_value("arst_blok", 32'(blok_aktif_o), 32'd0);
    check_value("arst_sonuc", sonuc_o, 32'd0);
    check_value("arst_F", 32'(filtre_sayac_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    sonuc_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    check_value("arst_rel_hazir", 32'(istek_hazir_o), 32'd1);
    check_value("arst_rel_gecerli", 32'(sonuc_gecerli_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
